scm_arbiter: RTL

- Sequencer and two-requester arbiter for one 1R1W standard-cell memory macro (DEPTH x DW, separate read/write ports, gated-clock write).
- Runs a clear sweep after reset, then shares the read and write ports independently between requesters A and B.
- All command outputs are registered, so the macro sees glitch-free RE/WE/address into its clock gates.

---
 rtl/scm_arbiter.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/scm_arbiter.sv
// SCM macro sequencer: clear sweep after reset, then two-requester arbitration of the 1R1W ports.
// Optional: define SCM_ARB_RR_EN for per-port round-robin priority (default is fixed A over B).
module scm_arbiter #(
   parameter int unsigned   AW       = 8,
   parameter int unsigned   DW       = 16,
   parameter int unsigned   RD_LAT   = 1,
   parameter logic [DW-1:0] INIT_VAL = '0
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          se_i,
   input  logic          a_req_i,
   input  logic          a_we_i,
   input  logic [AW-1:0] a_addr_i,
   input  logic [DW-1:0] a_wdata_i,
   input  logic          b_req_i,
   input  logic          b_we_i,
   input  logic [AW-1:0] b_addr_i,
   input  logic [DW-1:0] b_wdata_i,
   output logic          a_gnt_o,
   output logic          b_gnt_o,
   output logic          a_rvalid_o,
   output logic          b_rvalid_o,
   output logic [DW-1:0] a_rdata_o,
   output logic [DW-1:0] b_rdata_o,
   output logic          init_done_o,
   output logic          scm_re_o,
   output logic          scm_we_o,
   output logic [AW-1:0] scm_raddr_o,
   output logic [AW-1:0] scm_waddr_o,
   output logic [DW-1:0] scm_din_o,
   input  logic [DW-1:0] scm_dout_i,
   output logic          scm_se_o
);

   typedef enum logic {StInit, StRun} state_e;

   localparam logic [AW-1:0] LastRow = '1;

   state_e          state_q, state_d;
   logic [AW-1:0]   cnt_q, cnt_d;
   logic            init_done_q, init_done_d;
   logic            scm_re_q, scm_re_d, scm_we_q, scm_we_d;
   logic [AW-1:0]   raddr_q, raddr_d, waddr_q, waddr_d;
   logic [DW-1:0]   din_q, din_d;
   logic [RD_LAT:0] rv_q, rv_d, rid_q, rid_d;
   logic [DW-1:0]   a_rdata_q, b_rdata_q;

   logic          run, wr_a, wr_b, rd_a, rd_b, w_any, r_any;
   logic          w_sel_b, r_sel_b, r_hit, r_gnt;
   logic [AW-1:0] w_addr, r_addr;
   logic [DW-1:0] w_data;

   assign run   = (state_q == StRun);
   assign wr_a  = run & a_req_i & a_we_i;
   assign wr_b  = run & b_req_i & b_we_i;
   assign rd_a  = run & a_req_i & ~a_we_i;
   assign rd_b  = run & b_req_i & ~b_we_i;
   assign w_any = wr_a | wr_b;
   assign r_any = rd_a | rd_b;

`ifdef SCM_ARB_RR_EN
   // Pointer names the requester that wins the next contended cycle; it moves to the loser.
   logic w_ptr_q, w_ptr_d, r_ptr_q, r_ptr_d;

   assign w_sel_b = wr_b & (~wr_a | w_ptr_q);
   assign r_sel_b = rd_b & (~rd_a | r_ptr_q);
   assign w_ptr_d = w_any ? ~w_sel_b : w_ptr_q;
   assign r_ptr_d = r_gnt ? ~r_sel_b : r_ptr_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         w_ptr_q <= 1'b0;
         r_ptr_q <= 1'b0;
      end else begin
         w_ptr_q <= w_ptr_d;
         r_ptr_q <= r_ptr_d;
      end
   end
`else
   assign w_sel_b = wr_b & ~wr_a;
   assign r_sel_b = rd_b & ~rd_a;
`endif

   assign w_addr = w_sel_b ? b_addr_i : a_addr_i;
   assign w_data = w_sel_b ? b_wdata_i : a_wdata_i;
   assign r_addr = r_sel_b ? b_addr_i : a_addr_i;
   // A read to the row being written this cycle waits, keeping read-after-write order.
   assign r_hit  = w_any & (r_addr == w_addr);
   assign r_gnt  = r_any & ~r_hit;

   assign a_gnt_o = (w_any & ~w_sel_b) | (r_gnt & ~r_sel_b);
   assign b_gnt_o = (w_any & w_sel_b) | (r_gnt & r_sel_b);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      init_done_d = init_done_q;
      scm_we_d    = 1'b0;
      scm_re_d    = 1'b0;
      waddr_d     = waddr_q;
      raddr_d     = raddr_q;
      din_d       = din_q;
      case (state_q)
         StInit: begin
            scm_we_d = 1'b1;
            waddr_d  = cnt_q;
            din_d    = INIT_VAL;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == LastRow) begin
               init_done_d = 1'b1;
               state_d     = StRun;
            end
         end
         StRun: begin
            if (w_any) begin
               scm_we_d = 1'b1;
               waddr_d  = w_addr;
               din_d    = w_data;
            end
            if (r_gnt) begin
               scm_re_d = 1'b1;
               raddr_d  = r_addr;
            end
         end
         default: state_d = StInit;
      endcase
   end

   // Read return pipeline: stage k holds a grant issued k+1 cycles ago.
   always_comb begin
      rv_d     = rv_q;
      rid_d    = rid_q;
      rv_d[0]  = r_gnt;
      rid_d[0] = r_sel_b;
      for (int unsigned i = 1; i <= RD_LAT; i++) begin
         rv_d[i]  = rv_q[i-1];
         rid_d[i] = rid_q[i-1];
      end
   end

   assign a_rvalid_o = rv_q[RD_LAT] & ~rid_q[RD_LAT];
   assign b_rvalid_o = rv_q[RD_LAT] & rid_q[RD_LAT];
   assign a_rdata_o  = a_rvalid_o ? scm_dout_i : a_rdata_q;
   assign b_rdata_o  = b_rvalid_o ? scm_dout_i : b_rdata_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= StInit;
         cnt_q       <= '0;
         init_done_q <= 1'b0;
         scm_re_q    <= 1'b0;
         scm_we_q    <= 1'b0;
         raddr_q     <= '0;
         waddr_q     <= '0;
         din_q       <= '0;
         rv_q        <= '0;
         rid_q       <= '0;
         a_rdata_q   <= '0;
         b_rdata_q   <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         init_done_q <= init_done_d;
         scm_re_q    <= scm_re_d;
         scm_we_q    <= scm_we_d;
         raddr_q     <= raddr_d;
         waddr_q     <= waddr_d;
         din_q       <= din_d;
         rv_q        <= rv_d;
         rid_q       <= rid_d;
         a_rdata_q   <= a_rdata_o;
         b_rdata_q   <= b_rdata_o;
      end
   end

   assign init_done_o = init_done_q;
   assign scm_re_o    = scm_re_q;
   assign scm_we_o    = scm_we_q;
   assign scm_raddr_o = raddr_q;
   assign scm_waddr_o = waddr_q;
   assign scm_din_o   = din_q;
   assign scm_se_o    = se_i;

endmodule
